sram_bridge: RTL and testbench
==============================

# sram_bridge

Parametrised bridge between the pipelined CPU's single-word memory port and an external asynchronous SRAM narrower than the CPU word. It serialises each CPU access into `BEATS = CPU_W/MEM_W` SRAM beats with programmable wait states and byte-lane masking, and returns a completion pulse. It sits between `PipelineCPU` and the board SRAM pins, replacing the fixed 32-to-16 split and the divided-clock scheme with a full-rate handshake.

## Interface
- `CPU_W`, 32, CPU data width; a multiple of `MEM_W`, and `CPU_W/MEM_W` is a power of two
- `MEM_W`, 16, SRAM data width; a multiple of 8
- `ADR_W`, 20, SRAM address width
- `WAIT_STATES`, 0, extra cycles per beat (0..15)
- Derived: `BEATS = CPU_W/MEM_W`, `BL = log2(BEATS)`
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  access request; sampled only while `cpu_ready`=1
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_adr`  in  ADR_W-BL  CPU-word address
- `cpu_wdata`  in  CPU_W  write data
- `cpu_be`  in  CPU_W/8  byte enables for writes; bit 0 = byte [7:0]
- `cpu_ready`  out  1  bridge idle, can accept a request
- `cpu_done`  out  1  one-cycle completion pulse (reads and writes)
- `cpu_rdata`  out  CPU_W  read data; valid with `cpu_done` and held until the next read completes
- `sram_adr`  out  ADR_W  SRAM address
- `sram_dq_in`  in  MEM_W  SRAM data from the pads
- `sram_dq_out`  out  MEM_W  SRAM data to the pads
- `sram_dq_oe`  out  1  pad driver enable; the top level builds the tristate
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low chip enable, output enable, write enable
- `sram_be_n`  out  MEM_W/8  active-low byte lanes (UB/LB for 16-bit parts)

## Operation
- FSM states: `IDLE`, `SETUP`, `STROBE`.
- **IDLE**
  - `cpu_ready`=1.
  - On `cpu_req`=1, latch `cpu_we`, `cpu_adr`, `cpu_wdata` and `cpu_be`, set beat=0, go to `SETUP`.
  - Inputs changed after acceptance have no effect.
- **SETUP** (1 cycle)
  - Drive `sram_adr = {adr, beat}`, `sram_ce_n`=0 and `sram_be_n` from the beat's byte-enable slice.
  - Reads use all lanes active.
  - `sram_we_n`=1. `sram_oe_n` = `we`. `sram_dq_oe` = `we`. `sram_dq_out` = wdata slice `[beat*MEM_W +: MEM_W]`.
  - Go to `STROBE`.
- **STROBE** (`WAIT_STATES+1` cycles, counted by a wait counter)
  - Address, data and lanes are held.
  - For writes, `sram_we_n`=0.
  - On the last STROBE cycle:
    - `sram_we_n` returns to 1 at the next edge.
    - For reads, `sram_dq_in` is captured into `rdata[beat*MEM_W +: MEM_W]` at that edge.
  - Then: if beat = BEATS-1, go to `IDLE` and pulse `cpu_done`; else beat+1 and go to `SETUP`.
- **Beat order:** little-endian. Beat 0 carries the least-significant `MEM_W` bits at the lowest SRAM address.
- **Write-beat skipping:** a write beat whose byte-enable slice is all zero is skipped (no SETUP/STROBE cycles for it). A write with `cpu_be`=0 completes with `cpu_done` one cycle after acceptance and no SRAM activity.
- **Reads:** always execute all beats.
- **Idle SRAM outputs:** `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n` all 1, `sram_dq_oe`=0.
- **BEATS=1:** single beat, `{adr, beat}` degenerates to `adr`.

## Timing
- All outputs are registered except `cpu_ready` = (state==`IDLE`) & reset-released flag.
- **Reset values:**
  - `cpu_ready`=0; it goes to 1 on the first edge after `reset` deasserts.
  - `cpu_done`=0, `cpu_rdata`=0.
  - SRAM controls inactive (all `_n` outputs 1), `sram_dq_oe`=0, `sram_adr`=0, `sram_dq_out`=0.
- **Latency:** `cpu_done` is asserted `N*(WAIT_STATES+2)` cycles after the acceptance edge, where N = executed beats.
  - Defaults: 4 cycles for a full word.
- **Back-to-back:** `cpu_ready` is 1 in the same cycle as `cpu_done`, so a new request may be accepted then.
- **Write protocol:** address and data are stable one cycle before WE falls and remain stable through its rising edge.
- **Bus turnaround:** `sram_dq_oe` never overlaps `sram_oe_n`=0.
- **Async reset mid-access:**
  - All outputs take reset values immediately.
  - An in-flight access is abandoned, with no `cpu_done`.
  - Partial read data is discarded (`cpu_rdata`=0).

## Test plan
- **Reset:** reset low for 3 cycles, then release → `cpu_ready` 0 during reset and 1 one edge after release; all `_n` outputs 1; `sram_dq_oe`=0.
- **Full write:** write `cpu_adr`=0x12345, `cpu_wdata`=0xDEADBEEF, `cpu_be`=0xF →
  - beat 0: `sram_adr`=0x2468A, data 0xBEEF, WE low 1 cycle;
  - beat 1: `sram_adr`=0x2468B, data 0xDEAD;
  - `cpu_done` 4 cycles after acceptance.
- **Full read:** model returns 0x5678 at 0x00010 and 0x1234 at 0x00011; read `cpu_adr`=0x8 → `cpu_rdata`=0x12345678 with `cpu_done` after 4 cycles; `sram_dq_oe`=0 throughout.
- **Partial and empty writes:**
  - `cpu_be`=0xC → only beat 1 executes, `sram_be_n`=00, `cpu_done` after 2 cycles.
  - `cpu_be`=0x2 → beat 0 only, `sram_be_n`=01 (upper lane active).
  - `cpu_be`=0 → `cpu_done` after 1 cycle, no SRAM strobes.
- **Wait states:** with `WAIT_STATES`=2, a full read → each beat 4 cycles, WE/OE low 3 cycles, `cpu_done` at 8 cycles; back-to-back request accepted on the `cpu_done` cycle.
- **Reset mid-access:** assert reset during beat-1 STROBE of a write → outputs go to reset values immediately, no `cpu_done`, and a later read works normally.

Source files
------------

// File: rtl/sram_bridge_if.sv
// CPU memory-port and SRAM-pin bundle for sram_bridge.
// The slave modport is the bridge; the master modport is the CPU plus the SRAM pads.
interface sram_bridge_if #(
  parameter int CPU_W = 32,
  parameter int MEM_W = 16,
  parameter int ADR_W = 20
);
  localparam int BL = $clog2(CPU_W / MEM_W);

  // Handshake: a request is taken on any rising edge where cpu_req and
  // cpu_ready are both 1; cpu_done pulses for exactly one cycle per access.
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADR_W-BL-1:0]  cpu_adr;
  logic [CPU_W-1:0]     cpu_wdata;
  logic [CPU_W/8-1:0]   cpu_be;
  logic                 cpu_ready;
  logic                 cpu_done;
  logic [CPU_W-1:0]     cpu_rdata;

  logic [ADR_W-1:0]     sram_adr;
  logic [MEM_W-1:0]     sram_dq_in;
  logic [MEM_W-1:0]     sram_dq_out;
  logic                 sram_dq_oe;
  logic                 sram_ce_n;
  logic                 sram_oe_n;
  logic                 sram_we_n;
  logic [MEM_W/8-1:0]   sram_be_n;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_be, sram_dq_in,
    output cpu_ready, cpu_done, cpu_rdata,
    output sram_adr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_be, sram_dq_in,
    input  cpu_ready, cpu_done, cpu_rdata,
    input  sram_adr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_bridge.sv
// Serialises one CPU word access into CPU_W/MEM_W little-endian SRAM beats
// with programmable wait states, byte-lane masking and a done pulse.
module sram_bridge #(
  parameter int CPU_W       = 32,
  parameter int MEM_W       = 16,
  parameter int ADR_W       = 20,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         reset,
  sram_bridge_if.slave bus
);
  localparam int BEATS = CPU_W / MEM_W;
  localparam int BL    = $clog2(BEATS);
  localparam int BCW   = (BL > 0) ? BL : 1;
  localparam int BB    = MEM_W / 8;
  localparam int AW    = ADR_W - BL;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;

  logic [1:0]         r_state;
  logic               r_rst_done;
  logic               r_we;
  logic [AW-1:0]      r_adr;
  logic [CPU_W-1:0]   r_wdata;
  logic [CPU_W/8-1:0] r_be;
  logic [BCW-1:0]     r_beat;
  logic               r_empty;
  logic [3:0]         r_wait;
  logic [CPU_W-1:0]   r_rbuf;
  logic [CPU_W-1:0]   r_rdata;
  logic               r_done;
  logic [ADR_W-1:0]   r_sram_adr;
  logic [MEM_W-1:0]   r_dq_out;
  logic               r_dq_oe;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [BB-1:0]      r_be_n;

  logic               w_ready;
  logic               w_accept;
  logic               w_last_strobe;
  logic               w_first_valid;
  logic [BCW-1:0]     w_first_beat;
  logic               w_next_valid;
  logic [BCW-1:0]     w_next_beat;
  logic               w_ld_we;
  logic [AW-1:0]      w_ld_adr;
  logic [CPU_W-1:0]   w_ld_wdata;
  logic [CPU_W/8-1:0] w_ld_be;
  logic [BCW-1:0]     w_ld_beat;
  logic [ADR_W-1:0]   w_ld_sram_adr;
  logic [MEM_W-1:0]   w_ld_dq;
  logic [BB-1:0]      w_ld_be_n;
  logic [CPU_W-1:0]   w_rbuf_next;

  assign w_ready       = (r_state == S_IDLE) & r_rst_done;
  assign w_accept      = bus.cpu_req & w_ready;
  assign w_last_strobe = (r_wait == 4'(WAIT_STATES));

  // Beat selection: reads run every beat, writes skip beats with no enabled lanes.
  always_comb begin
    w_first_valid = 1'b0;
    w_first_beat  = '0;
    w_next_valid  = 1'b0;
    w_next_beat   = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (!bus.cpu_we || (bus.cpu_be[b*BB +: BB] != '0)) begin
        w_first_valid = 1'b1;
        w_first_beat  = BCW'(b);
      end
      if ((b > int'(r_beat)) && (!r_we || (r_be[b*BB +: BB] != '0))) begin
        w_next_valid = 1'b1;
        w_next_beat  = BCW'(b);
      end
    end
  end

  // Pad values for the beat about to enter SETUP: from the CPU inputs on
  // acceptance, otherwise from the latched request.
  always_comb begin
    w_ld_we       = (r_state == S_IDLE) ? bus.cpu_we    : r_we;
    w_ld_adr      = (r_state == S_IDLE) ? bus.cpu_adr   : r_adr;
    w_ld_wdata    = (r_state == S_IDLE) ? bus.cpu_wdata : r_wdata;
    w_ld_be       = (r_state == S_IDLE) ? bus.cpu_be    : r_be;
    w_ld_beat     = (r_state == S_IDLE) ? w_first_beat  : w_next_beat;
    w_ld_sram_adr = (ADR_W'(w_ld_adr) << BL) | ADR_W'(w_ld_beat);
    w_ld_dq       = w_ld_wdata[w_ld_beat*MEM_W +: MEM_W];
    w_ld_be_n     = w_ld_we ? ~w_ld_be[w_ld_beat*BB +: BB] : '0;
  end

  always_comb begin
    w_rbuf_next = r_rbuf;
    w_rbuf_next[r_beat*MEM_W +: MEM_W] = bus.sram_dq_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_beat     <= '0;
      r_empty    <= 1'b0;
      r_wait     <= '0;
      r_rbuf     <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_sram_adr <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_be_n     <= '1;
    end else begin
      r_rst_done <= 1'b1;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.cpu_we;
            r_adr   <= bus.cpu_adr;
            r_wdata <= bus.cpu_wdata;
            r_be    <= bus.cpu_be;
            r_beat  <= w_first_beat;
            r_empty <= !w_first_valid;
            r_state <= S_SETUP;
            if (w_first_valid) begin
              r_sram_adr <= w_ld_sram_adr;
              r_dq_out   <= w_ld_dq;
              r_be_n     <= w_ld_be_n;
              r_ce_n     <= 1'b0;
              r_oe_n     <= w_ld_we;
              r_dq_oe    <= w_ld_we;
              r_we_n     <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          // An all-lanes-off write spends this one cycle with the pads idle.
          if (r_empty) begin
            r_empty <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait  <= '0;
            r_we_n  <= !r_we;
            r_state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!w_last_strobe) begin
            r_wait <= r_wait + 4'd1;
          end else begin
            r_we_n <= 1'b1;
            if (!r_we) r_rbuf <= w_rbuf_next;
            if (w_next_valid) begin
              r_beat     <= w_next_beat;
              r_sram_adr <= w_ld_sram_adr;
              r_dq_out   <= w_ld_dq;
              r_be_n     <= w_ld_be_n;
              r_state    <= S_SETUP;
            end else begin
              if (!r_we) r_rdata <= w_rbuf_next;
              r_done  <= 1'b1;
              r_ce_n  <= 1'b1;
              r_oe_n  <= 1'b1;
              r_dq_oe <= 1'b0;
              r_be_n  <= '1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ready   = w_ready;
  assign bus.cpu_done    = r_done;
  assign bus.cpu_rdata   = r_rdata;
  assign bus.sram_adr    = r_sram_adr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_ce_n   = r_ce_n;
  assign bus.sram_oe_n   = r_oe_n;
  assign bus.sram_we_n   = r_we_n;
  assign bus.sram_be_n   = r_be_n;
endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: one zero-wait-state bridge for the main
// vector table and reset cases, one two-wait-state bridge for latency checks.
module tb_sram_bridge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 1'b0;
  logic        req2 = 1'b0;
  logic        t_we = 1'b0;
  logic [18:0] t_adr = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_be = '0;
  logic        cur_we = 1'b0;
  logic [15:0] mem [0:63];
  logic [37:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  sram_bridge_if #(.CPU_W(32), .MEM_W(16), .ADR_W(20)) if0 ();
  sram_bridge_if #(.CPU_W(32), .MEM_W(16), .ADR_W(20)) if2 ();

  assign if0.cpu_req    = req0;
  assign if0.cpu_we     = t_we;
  assign if0.cpu_adr    = t_adr;
  assign if0.cpu_wdata  = t_wdata;
  assign if0.cpu_be     = t_be;
  assign if0.sram_dq_in = mem[if0.sram_adr[5:0]];
  assign if2.cpu_req    = req2;
  assign if2.cpu_we     = t_we;
  assign if2.cpu_adr    = t_adr;
  assign if2.cpu_wdata  = t_wdata;
  assign if2.cpu_be     = t_be;
  assign if2.sram_dq_in = mem[if2.sram_adr[5:0]];

  sram_bridge #(.CPU_W(32), .MEM_W(16), .ADR_W(20), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  sram_bridge #(.CPU_W(32), .MEM_W(16), .ADR_W(20), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model and pin monitor for the zero-wait bridge: each WE-low cycle is one
  // write that must match the head of the expected-write queue.
  always @(posedge clk) begin
    if (reset && !if0.sram_ce_n) begin
      check("bus_dir", {62'd0, if0.sram_dq_oe, if0.sram_dq_oe & ~if0.sram_oe_n}, {62'd0, cur_we, 1'b0});
      if (!if0.sram_we_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none",
                   {if0.sram_adr, if0.sram_dq_out, if0.sram_be_n});
        end else begin
          check("sram_write", {26'd0, if0.sram_adr, if0.sram_dq_out, if0.sram_be_n}, {26'd0, exp_q.pop_front()});
        end
        if (!if0.sram_be_n[0]) mem[if0.sram_adr[5:0]][7:0]  = if0.sram_dq_out[7:0];
        if (!if0.sram_be_n[1]) mem[if0.sram_adr[5:0]][15:8] = if0.sram_dq_out[15:8];
      end
    end
  end

  task automatic do_acc(input bit sel, input logic we, input logic [18:0] adr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int cyc, output int waited);
    waited = 0;
    @(negedge clk);
    while (!(sel ? if2.cpu_ready : if0.cpu_ready) && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    cur_we  = we;
    t_we    = we;
    t_adr   = adr;
    t_wdata = wd;
    t_be    = be;
    if (sel) req2 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0    = 1'b0;
    req2    = 1'b0;
    t_we    = 1'($urandom_range(0, 1));
    t_adr   = 19'($urandom);
    t_wdata = $urandom;
    t_be    = 4'($urandom_range(0, 15));
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(sel ? if2.cpu_done : if0.cpu_done) && cyc < 60);
  endtask

  typedef struct {
    logic        we;
    logic [18:0] adr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
    logic [31:0] rdata;
    int          nwr;
    logic [19:0] wa0; logic [15:0] wd0; logic [1:0] wb0;
    logic [19:0] wa1; logic [15:0] wd1; logic [1:0] wb1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    int waited;

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[16] = 16'h5678;
    mem[17] = 16'h1234;

    vecs[0] = '{1'b1, 19'h12345, 32'hDEADBEEF, 4'hF, 4, 32'h00000000, 2,
                20'h2468A, 16'hBEEF, 2'b00, 20'h2468B, 16'hDEAD, 2'b00};
    vecs[1] = '{1'b0, 19'h00008, 32'h00000000, 4'h0, 4, 32'h12345678, 0,
                20'h0, 16'h0, 2'b00, 20'h0, 16'h0, 2'b00};
    vecs[2] = '{1'b1, 19'h12345, 32'hCAFE0000, 4'hC, 2, 32'h12345678, 1,
                20'h2468B, 16'hCAFE, 2'b00, 20'h0, 16'h0, 2'b00};
    vecs[3] = '{1'b1, 19'h12345, 32'h0000AB00, 4'h2, 2, 32'h12345678, 1,
                20'h2468A, 16'hAB00, 2'b01, 20'h0, 16'h0, 2'b00};
    vecs[4] = '{1'b1, 19'h12345, 32'hFFFFFFFF, 4'h0, 1, 32'h12345678, 0,
                20'h0, 16'h0, 2'b00, 20'h0, 16'h0, 2'b00};
    vecs[5] = '{1'b0, 19'h12345, 32'h00000000, 4'h0, 4, 32'hCAFEABEF, 0,
                20'h0, 16'h0, 2'b00, 20'h0, 16'h0, 2'b00};

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, if0.cpu_ready}, 64'd0);
    check("rst_ctrl_n", {61'd0, if0.sram_ce_n, if0.sram_oe_n, if0.sram_we_n}, 64'h7);
    check("rst_be_n", {62'd0, if0.sram_be_n}, 64'h3);
    check("rst_dq_oe", {63'd0, if0.sram_dq_oe}, 64'd0);
    check("rst_rdata", {32'd0, if0.cpu_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", {63'd0, if0.cpu_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", {63'd0, if0.cpu_ready}, 64'd1);

    // Vector table on the zero-wait bridge
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].nwr > 0) exp_q.push_back({vecs[i].wa0, vecs[i].wd0, vecs[i].wb0});
      if (vecs[i].nwr > 1) exp_q.push_back({vecs[i].wa1, vecs[i].wd1, vecs[i].wb1});
      do_acc(1'b0, vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].be, cyc, waited);
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_rdata", i), {32'd0, if0.cpu_rdata}, {32'd0, vecs[i].rdata});
      check($sformatf("v%0d_ready_on_done", i), {63'd0, if0.cpu_ready}, 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {63'd0, if0.cpu_done}, 64'd0);
      check($sformatf("v%0d_rdata_held", i), {32'd0, if0.cpu_rdata}, {32'd0, vecs[i].rdata});
    end
    check("writes_drained", 64'(exp_q.size()), 64'd0);

    // Two wait states: 8-cycle reads, second request taken in the done cycle
    do_acc(1'b1, 1'b0, 19'h00008, 32'h0, 4'h0, cyc, waited);
    check("ws2_latency_a", 64'(cyc), 64'd8);
    check("ws2_rdata_a", {32'd0, if2.cpu_rdata}, 64'h12345678);
    do_acc(1'b1, 1'b0, 19'h12345, 32'h0, 4'h0, cyc, waited);
    check("ws2_back_to_back", 64'(waited), 64'd0);
    check("ws2_latency_b", 64'(cyc), 64'd8);
    check("ws2_rdata_b", {32'd0, if2.cpu_rdata}, 64'hCAFEABEF);

    // Reset during the beat-1 strobe of a write
    exp_q.push_back({20'h00040, 16'h2222, 2'b00});
    @(negedge clk);
    cur_we  = 1'b1;
    t_we    = 1'b1;
    t_adr   = 19'h00020;
    t_wdata = 32'h11112222;
    t_be    = 4'hF;
    req0    = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_we_low", {63'd0, if0.sram_we_n}, 64'd0);
    check("mid_adr_beat1", {44'd0, if0.sram_adr}, 64'h00041);
    reset = 1'b0;
    #1;
    check("mid_ctrl_n", {61'd0, if0.sram_ce_n, if0.sram_oe_n, if0.sram_we_n}, 64'h7);
    check("mid_be_n", {62'd0, if0.sram_be_n}, 64'h3);
    check("mid_dq_oe", {63'd0, if0.sram_dq_oe}, 64'd0);
    check("mid_adr", {44'd0, if0.sram_adr}, 64'd0);
    check("mid_dq_out", {48'd0, if0.sram_dq_out}, 64'd0);
    check("mid_ready", {63'd0, if0.cpu_ready}, 64'd0);
    check("mid_rdata", {32'd0, if0.cpu_rdata}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_no_done_rst", {63'd0, if0.cpu_done}, 64'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_no_done_after", {63'd0, if0.cpu_done}, 64'd0);
    end
    check("mid_write_log", 64'(exp_q.size()), 64'd0);
    do_acc(1'b0, 1'b0, 19'h00008, 32'h0, 4'h0, cyc, waited);
    check("post_rst_latency", 64'(cyc), 64'd4);
    check("post_rst_rdata", {32'd0, if0.cpu_rdata}, 64'h12345678);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
